// File: rtl/ss_displayer.sv
// Four-digit multiplexed 7-segment driver. Each slot starts with a blank interval,
// then latches that digit's pattern so mid-slot input changes cannot tear the display.
module ss_displayer #(
  parameter int unsigned REFRESH_DIV  = 25000,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg3,
  input  logic [6:0] seg2,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  input  logic [3:0] digit_en,
  input  logic [3:0] dp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] LatchCnt = CntW'(BLANK_CYCLES - 1);

  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]      digit_idx_q, digit_idx_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            frame_tick_q, frame_tick_d;
  logic [6:0]      sel_seg;
  logic            slot_end, slot_latch;

  assign slot_end   = (tick_cnt_q == LastCnt);
  assign slot_latch = (tick_cnt_q == LatchCnt);

  always_comb begin
    sel_seg = seg0;
    unique case (digit_idx_q)
      2'd0: sel_seg = seg0;
      2'd1: sel_seg = seg1;
      2'd2: sel_seg = seg2;
      2'd3: sel_seg = seg3;
      default: sel_seg = seg0;
    endcase
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q + CntW'(1);
    digit_idx_d  = digit_idx_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    an_d         = an_q;
    frame_tick_d = 1'b0;
    if (slot_end) begin
      tick_cnt_d   = '0;
      digit_idx_d  = digit_idx_q + 2'd1;
      seg_d        = 7'h7f;
      dp_d         = 1'b1;
      an_d         = 4'b1111;
      // Only the 3->0 wrap marks a frame start, so the first slot after reset stays quiet.
      frame_tick_d = (digit_idx_q == 2'd3);
    end else if (slot_latch) begin
      seg_d = sel_seg;
      dp_d  = ~dp_en[digit_idx_q];
      an_d  = digit_en[digit_idx_q] ? ~(4'b0001 << digit_idx_q) : 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_q   <= '0;
      digit_idx_q  <= 2'd0;
      seg_q        <= 7'h7f;
      dp_q         <= 1'b1;
      an_q         <= 4'b1111;
      frame_tick_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      digit_idx_q  <= digit_idx_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ss_displayer.sv
// Directed bench for ss_displayer with REFRESH_DIV=8, BLANK_CYCLES=2.
// cyc counts edges since the last reset edge, so tick_cnt == cyc % 8.
module tb_ss_displayer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] seg3, seg2, seg1, seg0;
  logic [3:0] digit_en, dp_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [6:0] pat    [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
  logic [3:0] an_lit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  ss_displayer #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg3      (seg3),
    .seg2      (seg2),
    .seg1      (seg1),
    .seg0      (seg0),
    .digit_en  (digit_en),
    .dp_en     (dp_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] slot_of(input int c);
    slot_of = 2'((c / 8) % 4);
  endfunction

  function automatic bit lit_of(input int c);
    lit_of = (c % 8) >= 2;
  endfunction

  task automatic set_defaults();
    seg0 = pat[0]; seg1 = pat[1]; seg2 = pat[2]; seg3 = pat[3];
    digit_en = 4'b1111;
    dp_en    = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    seg0 = 7'h2a; seg1 = 7'h15; seg2 = 7'h00; seg3 = 7'h33;
    digit_en = 4'b1111;
    dp_en    = 4'b1111;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (an !== 4'b1111) begin
        errors++; $display("FAIL reset_an cycle %0d: got %b want 1111", i, an);
      end
      checks++;
      if (seg !== 7'h7f) begin
        errors++; $display("FAIL reset_seg cycle %0d: got %b want 1111111", i, seg);
      end
      checks++;
      if (dp !== 1'b1) begin
        errors++; $display("FAIL reset_dp cycle %0d: got %b want 1", i, dp);
      end
      checks++;
      if (digit_idx !== 2'd0) begin
        errors++; $display("FAIL reset_idx cycle %0d: got %0d want 0", i, digit_idx);
      end
      checks++;
      if (frame_tick !== 1'b0) begin
        errors++; $display("FAIL reset_ftick cycle %0d: got %b want 0", i, frame_tick);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [1:0] s;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    set_defaults();
    do_reset();
    while (cyc <= 40) begin
      s       = slot_of(cyc);
      exp_an  = lit_of(cyc) ? an_lit[s] : 4'b1111;
      exp_seg = lit_of(cyc) ? pat[s] : 7'h7f;
      checks++;
      if (an !== exp_an) begin
        errors++; $display("FAIL scan_an cycle %0d: got %b want %b", cyc, an, exp_an);
      end
      checks++;
      if (seg !== exp_seg) begin
        errors++; $display("FAIL scan_seg cycle %0d: got %b want %b", cyc, seg, exp_seg);
      end
      checks++;
      if (dp !== 1'b1) begin
        errors++; $display("FAIL scan_dp cycle %0d: got %b want 1", cyc, dp);
      end
      checks++;
      if (digit_idx !== s) begin
        errors++; $display("FAIL scan_idx cycle %0d: got %0d want %0d", cyc, digit_idx, s);
      end
      checks++;
      if (frame_tick !== (cyc == 32)) begin
        errors++;
        $display("FAIL scan_ftick cycle %0d: got %b want %b", cyc, frame_tick, cyc == 32);
      end
      step();
    end
  endtask

  task automatic test_digit_disable();
    logic [1:0] s;
    logic [3:0] exp_an;
    set_defaults();
    digit_en = 4'b1011;
    do_reset();
    while (cyc <= 40) begin
      s      = slot_of(cyc);
      exp_an = (lit_of(cyc) && s != 2'd2) ? an_lit[s] : 4'b1111;
      checks++;
      if (an !== exp_an) begin
        errors++; $display("FAIL disable_an cycle %0d: got %b want %b", cyc, an, exp_an);
      end
      // Data still loads for a disabled digit even though its anode stays off.
      if (s == 2'd2 && lit_of(cyc)) begin
        checks++;
        if (seg !== pat[2]) begin
          errors++; $display("FAIL disable_seg cycle %0d: got %b want %b", cyc, seg, pat[2]);
        end
      end
      step();
    end
  endtask

  task automatic test_decimal_point();
    logic exp_dp;
    set_defaults();
    dp_en = 4'b0100;
    do_reset();
    while (cyc <= 56) begin
      exp_dp = !(slot_of(cyc) == 2'd2 && lit_of(cyc));
      checks++;
      if (dp !== exp_dp) begin
        errors++; $display("FAIL dp cycle %0d: got %b want %b", cyc, dp, exp_dp);
      end
      step();
    end
  endtask

  task automatic test_no_tearing();
    set_defaults();
    do_reset();
    while (cyc <= 47) begin
      if (cyc >= 10 && cyc <= 15) begin
        checks++;
        if (seg !== 7'b1111001) begin
          errors++; $display("FAIL tear_hold cycle %0d: got %b want 1111001", cyc, seg);
        end
      end
      if (cyc >= 42) begin
        checks++;
        if (seg !== 7'b0000000) begin
          errors++; $display("FAIL tear_new cycle %0d: got %b want 0000000", cyc, seg);
        end
      end
      if (cyc == 12) seg1 = 7'b0000000;
      step();
    end
    set_defaults();
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] exp_an;
    set_defaults();
    do_reset();
    while (cyc < 21) step();
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1111) begin
      errors++; $display("FAIL midrst_an: got %b want 1111", an);
    end
    checks++;
    if (digit_idx !== 2'd0) begin
      errors++; $display("FAIL midrst_idx: got %0d want 0", digit_idx);
    end
    checks++;
    if (seg !== 7'h7f) begin
      errors++; $display("FAIL midrst_seg: got %b want 1111111", seg);
    end
    rst = 1'b1;
    cyc = 0;
    while (cyc <= 33) begin
      exp_an = lit_of(cyc) ? an_lit[slot_of(cyc)] : 4'b1111;
      checks++;
      if (an !== exp_an) begin
        errors++; $display("FAIL midrst_scan_an cycle %0d: got %b want %b", cyc, an, exp_an);
      end
      checks++;
      if (frame_tick !== (cyc == 32)) begin
        errors++;
        $display("FAIL midrst_ftick cycle %0d: got %b want %b", cyc, frame_tick, cyc == 32);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_digit_disable();
    test_decimal_point();
    test_no_tearing();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ss_displayer.md
Name: ss_displayer

Overview:
- Time-multiplexes four pre-decoded, active-low 7-segment patterns onto the board's shared cathode bus and four active-low anodes.
- Sits directly downstream of the segment decoder: it consumes seg3..seg0 and drives the FPGA pins.
- Each digit slot begins with an anti-ghosting blank interval.
- Segment data is latched once per slot, so input changes never tear a lit digit.

Parameters:
- REFRESH_DIV, 25000: clk cycles per digit slot (1 ms at 25 MHz, 250 Hz frame); legal range >= 2.
- BLANK_CYCLES, 250: cycles at the start of each slot with all anodes off; legal range 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  input  1  25 MHz system clock.
- rst  input  1  Reset, synchronous, active-low. Sampled only on the rising edge of clk.
- seg3  input  7  Active-low pattern, leftmost digit.
- seg2  input  7  Active-low pattern, digit 2.
- seg1  input  7  Active-low pattern, digit 1.
- seg0  input  7  Active-low pattern, rightmost digit.
- digit_en  input  4  Per-digit enable; bit i=0 keeps anode i off for its whole slot.
- dp_en  input  4  Per-digit decimal point request; bit i=1 lights dp during slot i.
- seg  output  7  Cathode bus, active-low, registered.
- dp  output  1  Decimal point cathode, active-low, registered.
- an  output  4  Anodes, active-low, one-hot-low when lit; an[0] is the rightmost digit; registered.
- digit_idx  output  2  Index of the current slot.
- frame_tick  output  1  One-cycle pulse at the start of each frame (slot 0).

Behaviour:
- Reset: on a rising edge with rst=0, set tick_cnt=0, digit_idx=0, an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0. Reset asserted mid-slot aborts the slot; scanning restarts at slot 0 with a full blank interval after release.
- tick_cnt counts 0..REFRESH_DIV-1. Its width is the minimum needed to hold REFRESH_DIV-1.
- Slot wrap: at an edge where tick_cnt==REFRESH_DIV-1:
  - tick_cnt becomes 0.
  - digit_idx increments modulo 4 (3 wraps to 0).
  - seg, dp and an load blank values: an=1111, seg=7F, dp=1.
- Slot latch: at an edge where tick_cnt==BLANK_CYCLES-1:
  - seg loads seg[digit_idx].
  - dp loads ~dp_en[digit_idx].
  - an loads ~(4'b0001<<digit_idx) if digit_en[digit_idx]=1, else 4'b1111.
  - Inputs are sampled only at this edge.
- Output windows:
  - Lit while tick_cnt is in BLANK_CYCLES..REFRESH_DIV-1.
  - Blank while tick_cnt is in 0..BLANK_CYCLES-1.
  - If digit_en is 0 for the slot, seg and dp still load data but the anode stays off.
- frame_tick: registered; 1 for exactly the cycle in which digit_idx==0 and tick_cnt==0 following a 3->0 wrap. Period is 4*REFRESH_DIV cycles. Not asserted on the first slot after reset.
- Mid-slot input changes (seg*, digit_en, dp_en) have no effect until the next latch edge of the affected slot.
- No combinational path from any input to any output.

Test Plan:
(All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2. "Cycle n" is the n-th rising edge after rst goes 1; tick_cnt equals n mod 8 after that edge.)
- Reset: hold rst=0 for 3 cycles with arbitrary inputs -> an=1111, seg=1111111, dp=1, digit_idx=0, frame_tick=0 after the first reset edge, held throughout.
- Basic scan: seg0=1000000, seg1=1111001, seg2=0100100, seg3=0110000, digit_en=1111, dp_en=0000 -> required response:
  - Cycles 0-1: an=1111.
  - Cycles 2-7: an=1110, seg=1000000.
  - Cycles 8-9: blank.
  - Cycles 10-15: an=1101, seg=1111001.
  - Cycles 18-23: an=1011.
  - Cycles 26-31: an=0111, seg=0110000.
  - frame_tick=1 only at cycles 32, 64, ...
- Digit disable: digit_en=1011, other inputs as in the basic scan -> an=1111 for all of cycles 16-23; the other slots are unchanged.
- Decimal point: dp_en=0100 -> dp=0 only during cycles 18-23 (and 50-55, ...); dp=1 elsewhere.
- No tearing: change seg1 from 1111001 to 0000000 at cycle 12 -> seg stays 1111001 through cycle 15; seg shows 0000000 during cycles 42-47.
- Reset mid-scan: drive rst=0 at cycle 21 for 1 cycle -> an=1111, digit_idx=0 on the next edge; after release, the slot-0 blank/lit pattern restarts from tick_cnt=0 and frame_tick does not pulse until a full frame has elapsed.
